// File: rtl/regfile_wb_scheduler_if.sv
// Writeback-scheduler bus: issue port, two writeback requesters,
// register-file write port and scoreboard status.
interface regfile_wb_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
);
  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [ADDR_WIDTH-1:0] issue_rs1;
  logic [ADDR_WIDTH-1:0] issue_rs2;
  logic                  issue_stall;

  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;

  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;

  logic                  rf_regWrite;
  logic [ADDR_WIDTH-1:0] rf_writeRegister;
  logic [DATA_WIDTH-1:0] rf_writeData;

  logic [NREG-1:0]       busy;
  logic                  wb_orphan;
  logic [CNT_WIDTH-1:0]  conflict_count;

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  issue_stall, a_ready, b_ready,
    input  rf_regWrite, rf_writeRegister, rf_writeData,
    input  busy, wb_orphan, conflict_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output issue_stall, a_ready, b_ready,
    output rf_regWrite, rf_writeRegister, rf_writeData,
    output busy, wb_orphan, conflict_count
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the single register-file write port between the
// ALU (A) and load unit (B), with a busy scoreboard that stalls RAW/WAW issue.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wb_scheduler_if.slave bus
);
  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  grant_e                r_last, w_last_nxt;
  logic [NREG-1:0]       r_busy, w_busy_nxt;
  logic                  r_orphan, w_orphan_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;

  logic                  w_req_a, w_req_b, w_grant, w_we, w_issue_ok;
  logic                  w_haz_rs1, w_haz_rs2, w_haz_rd, w_stall;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // Arbitration and write-port mux; reset suppresses any grant.
  always_comb begin
    w_req_a = bus.a_valid && (!bus.b_valid || (r_last == GRANT_B));
    w_req_b = bus.b_valid && (!bus.a_valid || (r_last == GRANT_A));
    w_grant = (w_req_a || w_req_b) && !reset;
    w_addr  = w_req_b ? bus.b_addr : bus.a_addr;
    w_data  = w_req_b ? bus.b_data : bus.a_data;
    w_we    = w_grant && (w_addr != '0);
  end

  // Hazard detection against the scoreboard (no bypass from this cycle's write).
  always_comb begin
    w_haz_rs1  = (bus.issue_rs1 != '0) && r_busy[bus.issue_rs1];
    w_haz_rs2  = (bus.issue_rs2 != '0) && r_busy[bus.issue_rs2];
    w_haz_rd   = (bus.issue_rd  != '0) && r_busy[bus.issue_rd];
    w_stall    = bus.issue_valid && (w_haz_rs1 || w_haz_rs2 || w_haz_rd);
    w_issue_ok = bus.issue_valid && !w_stall && (bus.issue_rd != '0);
  end

  // Next-state: grant history, scoreboard (set beats clear), orphan, counter.
  always_comb begin
    w_last_nxt   = r_last;
    w_busy_nxt   = r_busy;
    w_orphan_nxt = 1'b0;
    w_cnt_nxt    = r_cnt;

    if (w_req_a)      w_last_nxt = GRANT_A;
    else if (w_req_b) w_last_nxt = GRANT_B;

    if (w_we) begin
      w_busy_nxt[w_addr] = 1'b0;
      w_orphan_nxt       = !r_busy[w_addr];
    end
    if (w_issue_ok) w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;

    if (bus.a_valid && bus.b_valid && (r_cnt != '1))
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last   <= GRANT_B;
      r_busy   <= '0;
      r_orphan <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_last   <= w_last_nxt;
      r_busy   <= w_busy_nxt;
      r_orphan <= w_orphan_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.a_ready          = w_req_a && !reset;
  assign bus.b_ready          = w_req_b && !reset;
  assign bus.rf_regWrite      = w_we;
  assign bus.rf_writeRegister = w_addr;
  assign bus.rf_writeData     = w_data;
  assign bus.issue_stall      = w_stall;
  assign bus.busy             = r_busy;
  assign bus.wb_orphan        = r_orphan;
  assign bus.conflict_count   = r_cnt;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_scheduler;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;
  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) ifc ();

  regfile_wb_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Register file fed by the DUT write port; r0 never written.
  logic [DW-1:0] rf_mem [NR];
  always @(posedge clk)
    if (ifc.rf_regWrite && (ifc.rf_writeRegister != '0))
      rf_mem[ifc.rf_writeRegister] <= ifc.rf_writeData;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic [NR-1:0] m_busy;
  bit            m_a_turn;
  bit            m_orphan;
  int unsigned   m_cnt;
  logic [DW-1:0] m_rf [NR];
  bit            m_init = 1'b0;

  // Per-cycle compare, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    bit ga, gb, we, st;
    logic [AW-1:0] ad;
    logic [DW-1:0] dt;
    ga = ifc.a_valid && (!ifc.b_valid || m_a_turn) && !reset;
    gb = ifc.b_valid && (!ifc.a_valid || !m_a_turn) && !reset;
    ad = gb ? ifc.b_addr : ifc.a_addr;
    dt = gb ? ifc.b_data : ifc.a_data;
    we = (ga || gb) && (ad != '0);
    st = ifc.issue_valid &&
         (((ifc.issue_rs1 != '0) && m_busy[ifc.issue_rs1]) ||
          ((ifc.issue_rs2 != '0) && m_busy[ifc.issue_rs2]) ||
          ((ifc.issue_rd  != '0) && m_busy[ifc.issue_rd]));

    chk("a_ready", 64'(ifc.a_ready), 64'(ga));
    chk("b_ready", 64'(ifc.b_ready), 64'(gb));
    chk("rf_regWrite", 64'(ifc.rf_regWrite), 64'(we));
    if (we) begin
      chk("rf_writeRegister", 64'(ifc.rf_writeRegister), 64'(ad));
      chk("rf_writeData", 64'(ifc.rf_writeData), 64'(dt));
    end
    if (m_init) begin
      chk("issue_stall", 64'(ifc.issue_stall), 64'(st));
      chk("busy", 64'(ifc.busy), 64'(m_busy));
      chk("wb_orphan", 64'(ifc.wb_orphan), 64'(m_orphan));
      chk("conflict_count", 64'(ifc.conflict_count), 64'(m_cnt));
    end

    if (reset) begin
      m_busy   = '0;
      m_a_turn = 1'b1;
      m_orphan = 1'b0;
      m_cnt    = 0;
      m_init   = 1'b1;
    end else begin
      m_orphan = we && !m_busy[ad];
      if (we) begin
        m_busy[ad] = 1'b0;
        m_rf[ad]   = dt;
      end
      if (ifc.issue_valid && !st && (ifc.issue_rd != '0)) m_busy[ifc.issue_rd] = 1'b1;
      if (ga)      m_a_turn = 1'b0;
      else if (gb) m_a_turn = 1'b1;
      if (ifc.a_valid && ifc.b_valid && (m_cnt < 32'd65535)) m_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.issue_valid = 1'b0; ifc.issue_rd = '0; ifc.issue_rs1 = '0; ifc.issue_rs2 = '0;
    ifc.a_valid = 1'b0; ifc.a_addr = '0; ifc.a_data = '0;
    ifc.b_valid = 1'b0; ifc.b_addr = '0; ifc.b_data = '0;
  endtask

  task automatic issue(input int rd, input int rs1, input int rs2);
    ifc.issue_valid = 1'b1;
    ifc.issue_rd  = AW'(rd);
    ifc.issue_rs1 = AW'(rs1);
    ifc.issue_rs2 = AW'(rs2);
  endtask

  initial begin
    bit a_hs, b_hs, st_hold;
    reset = 1'b1;
    idle();
    for (int i = 0; i < int'(NR); i++) begin
      rf_mem[i] = '0;
      m_rf[i]   = '0;
    end
    repeat (2) cyc();
    reset = 1'b0;

    // RAW stall and release by an A writeback.
    issue(2, 0, 0);
    @(negedge clk) chk("t1_first_issue_stall", 64'(ifc.issue_stall), 64'd0);
    cyc();
    issue(1, 2, 0);
    ifc.a_valid = 1'b1; ifc.a_addr = AW'(2); ifc.a_data = DW'(42);
    @(negedge clk);
    chk("t1_raw_stall", 64'(ifc.issue_stall), 64'd1);
    chk("t1_busy2", 64'(ifc.busy[2]), 64'd1);
    chk("t1_regwrite", 64'(ifc.rf_regWrite), 64'd1);
    cyc();
    ifc.a_valid = 1'b0;
    @(negedge clk);
    chk("t1_reissue_stall", 64'(ifc.issue_stall), 64'd0);
    chk("t1_busy2_clear", 64'(ifc.busy[2]), 64'd0);
    chk("t1_r2", 64'(rf_mem[2]), 64'd42);
    cyc();
    idle();

    // Alternating grants under a sustained conflict.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ifc.a_valid = 1'b1; ifc.a_addr = AW'(5); ifc.a_data = DW'(1);
    ifc.b_valid = 1'b1; ifc.b_addr = AW'(6); ifc.b_data = DW'(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_a_ready", 64'(ifc.a_ready), 64'((i % 2) == 0));
      chk("t2_b_ready", 64'(ifc.b_ready), 64'((i % 2) == 1));
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t2_conflicts", 64'(ifc.conflict_count), 64'd4);
    chk("t2_r5", 64'(rf_mem[5]), 64'd1);
    chk("t2_r6", 64'(rf_mem[6]), 64'd2);

    // Writes and issues targeting r0.
    issue(0, 0, 0);
    ifc.a_valid = 1'b1; ifc.a_addr = '0; ifc.a_data = DW'(15);
    @(negedge clk);
    chk("t3_a_ready", 64'(ifc.a_ready), 64'd1);
    chk("t3_regwrite", 64'(ifc.rf_regWrite), 64'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("t3_busy", 64'(ifc.busy), 64'd0);
    chk("t3_orphan", 64'(ifc.wb_orphan), 64'd0);
    chk("t3_r0", 64'(rf_mem[0]), 64'd0);

    // Orphan writeback pulse.
    ifc.a_valid = 1'b1; ifc.a_addr = AW'(9); ifc.a_data = DW'(99);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_orphan_hi", 64'(ifc.wb_orphan), 64'd1);
    chk("t4_r9", 64'(rf_mem[9]), 64'd99);
    cyc();
    @(negedge clk) chk("t4_orphan_lo", 64'(ifc.wb_orphan), 64'd0);

    // WAW stall released by a B writeback.
    issue(3, 0, 0);
    cyc();
    ifc.b_valid = 1'b1; ifc.b_addr = AW'(3); ifc.b_data = DW'(33);
    @(negedge clk);
    chk("t5_waw_stall", 64'(ifc.issue_stall), 64'd1);
    chk("t5_busy", 64'(ifc.busy), 64'h8);
    chk("t5_b_ready", 64'(ifc.b_ready), 64'd1);
    cyc();
    ifc.b_valid = 1'b0;
    @(negedge clk);
    chk("t5_stall_released", 64'(ifc.issue_stall), 64'd0);
    chk("t5_busy_clear", 64'(ifc.busy), 64'h0);
    cyc();
    idle();
    @(negedge clk) chk("t5_busy_reset", 64'(ifc.busy), 64'h8);

    // Reset mid-operation with pending requests.
    issue(2, 0, 0);
    cyc();
    idle();
    reset = 1'b1;
    ifc.a_valid = 1'b1; ifc.a_addr = AW'(4); ifc.a_data = DW'(44);
    ifc.b_valid = 1'b1; ifc.b_addr = AW'(5); ifc.b_data = DW'(55);
    @(negedge clk);
    chk("t6_busy_pre", 64'(ifc.busy), 64'hC);
    chk("t6_no_write", 64'(ifc.rf_regWrite), 64'd0);
    chk("t6_no_a", 64'(ifc.a_ready), 64'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy_post", 64'(ifc.busy), 64'h0);
    chk("t6_cnt_post", 64'(ifc.conflict_count), 64'd0);
    chk("t6_orphan_post", 64'(ifc.wb_orphan), 64'd0);
    chk("t6_first_grant_a", 64'(ifc.a_ready), 64'd1);
    cyc();
    ifc.a_valid = 1'b0;
    @(negedge clk) chk("t6_then_b", 64'(ifc.b_ready), 64'd1);
    cyc();
    idle();
    @(negedge clk) chk("t6_r4", 64'(rf_mem[4]), 64'd44);

    // Randomized traffic obeying the hold-until-ready protocol.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_hs    = ifc.a_valid && ifc.a_ready;
      b_hs    = ifc.b_valid && ifc.b_ready;
      st_hold = ifc.issue_valid && ifc.issue_stall;
      cyc();
      reset = ($urandom_range(0, 299) == 0);
      if (!ifc.a_valid || a_hs) begin
        ifc.a_valid = ($urandom_range(0, 2) != 0);
        ifc.a_addr  = AW'($urandom_range(0, 7));
        ifc.a_data  = DW'($urandom);
      end
      if (!ifc.b_valid || b_hs) begin
        ifc.b_valid = ($urandom_range(0, 2) != 0);
        ifc.b_addr  = AW'($urandom_range(0, 7));
        ifc.b_data  = DW'($urandom);
      end
      if (!st_hold) begin
        ifc.issue_valid = ($urandom_range(0, 2) != 0);
        ifc.issue_rd    = AW'($urandom_range(0, 7));
        ifc.issue_rs1   = AW'($urandom_range(0, 7));
        ifc.issue_rs2   = AW'($urandom_range(0, 7));
      end
    end
    reset = 1'b0;
    idle();
    repeat (2) cyc();

    for (int i = 0; i < int'(NR); i++)
      chk("final_regfile", 64'(rf_mem[i]), 64'(m_rf[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single synchronous write port of the 32x32 register file between two writeback requesters: A (ALU) and B (load unit).
- Keeps a 32-entry busy scoreboard of registers with writes in flight.
- Stalls issue on RAW and WAW hazards against that scoreboard.
- Sits between decode/issue, the execution units and the register file write port (regWrite / writeRegister / writeData).

Parameters:
DATA_WIDTH, 32, width of writeback data
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
CNT_WIDTH, 16, width of saturating conflict counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
issue_valid  in  1  decode presents an instruction
issue_rd  in  ADDR_WIDTH  destination register of issuing instruction
issue_rs1  in  ADDR_WIDTH  source register 1
issue_rs2  in  ADDR_WIDTH  source register 2
issue_stall  out  1  issue must hold this cycle
a_valid  in  1  requester A has writeback
a_addr  in  ADDR_WIDTH  A destination
a_data  in  DATA_WIDTH  A data
a_ready  out  1  A granted this cycle
b_valid  in  1  requester B has writeback
b_addr  in  ADDR_WIDTH  B destination
b_data  in  DATA_WIDTH  B data
b_ready  out  1  B granted this cycle
rf_regWrite  out  1  register file write enable
rf_writeRegister  out  ADDR_WIDTH  register file write address
rf_writeData  out  DATA_WIDTH  register file write data
busy  out  2**ADDR_WIDTH  scoreboard bit vector
wb_orphan  out  1  one-cycle pulse: granted writeback targeted a non-busy register
conflict_count  out  CNT_WIDTH  cycles with both a_valid and b_valid high

Behaviour:
Reset (reset high at posedge):
- busy=0, last_grant=B (so A wins first conflict), wb_orphan=0, conflict_count=0.
- Combinational outputs still follow inputs during reset, but rf_regWrite, a_ready and b_ready are forced 0.

Arbitration (combinational, single cycle):
- Only one valid: grant it.
- Both valid: grant the requester not named in last_grant.
- Neither valid: no grant; last_grant holds.
- On any grant, last_grant <= granted requester at posedge.
- Handshake completes in a cycle where valid & ready. Requester holds valid/addr/data stable until ready. Ungranted requester waits; no data buffering inside this block.

Write port:
- rf_writeRegister/rf_writeData = granted requester's addr/data (A's when no grant).
- rf_regWrite = grant & (addr != 0).
- A write to r0 is still handshaked (ready=1) but produces no write.
- Register file captures on the same posedge; readData reflects the new value after that edge (zero added latency).

Scoreboard:
- Hazard per source: src!=0 & busy[src]. Same rule for rd (WAW).
- issue_stall = issue_valid & (hazard(rs1) | hazard(rs2) | hazard(rd)).
- Accepted issue = issue_valid & !issue_stall & rd!=0: busy[rd] <= 1.
- Granted writeback with addr!=0: busy[addr] <= 0.
- Simultaneous set and clear of the same register: set wins. This is unreachable via a legal issue because of the WAW check, but it must be defined.
- busy[0] is constant 0.
- No bypass: an issue reading a register being written this cycle still stalls. It issues the following cycle.

wb_orphan:
- Registered; pulses 1 cycle after a granted writeback with addr!=0 and busy[addr]==0.
- Write still performed.

conflict_count:
- +1 each cycle with a_valid & b_valid, saturating at all-ones.

Reset mid-operation:
- Scoreboard and counters cleared next edge.
- In-flight handshakes in the reset cycle are not granted and no write occurs.

Test Plan:
- Reset, then issue rd=2 rs1=0 rs2=0 -> stall=0, busy[2]=1 next cycle; issue rs1=2 -> stall=1; A writes r2=42 -> rf_regWrite=1, busy[2]=0 next cycle, readData of r2=42, re-issue stall=0.
- a_valid and b_valid both held 4 cycles (A r5=1, B r6=2, each re-asserted after grant) -> grants A,B,A,B; conflict_count=4; r5=1, r6=2.
- Issue rd=0 and A writeback to r0 data 15 -> a_ready=1, rf_regWrite=0, busy unchanged, r0 reads 0, wb_orphan=0.
- A writes r9 with busy[9]=0 -> write occurs, wb_orphan=1 for exactly one cycle.
- busy[3]=1, issue rd=3 -> stall (WAW); same cycle B writes r3 -> busy[3]=0 next cycle, issue accepted then, busy[3]=1 again.
- Assert reset while busy=0x0000000C and both requesters valid -> no write that cycle; busy=0, conflict_count=0, wb_orphan=0 after edge; first conflict after reset grants A.
